// File: rtl/proc_clk_ctrl.sv
// Processor clock-enable controller: divides clk into proc_ce and freezes it while any stall channel requests.
// Define PROC_CLK_PERF_EN to build the ce_count / stall_count performance counters.

module proc_clk_ack_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  output logic ack
);
  always_ff @(posedge clk) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= req;
  end
endmodule

module proc_clk_ctrl #(
  parameter int DIV           = 1,
  parameter int NUM_STALL     = 2,
  parameter int RESUME_CYCLES = 1,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_STALL-1:0] stall_req,
  output logic                 proc_ce,
  output logic [NUM_STALL-1:0] stall_ack,
  output logic                 stall_active,
  output logic                 stall_timeout,
  output logic [31:0]          ce_count,
  output logic [31:0]          stall_count
);
  localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [3:0]    RES_LAST = 4'((RESUME_CYCLES > 0) ? RESUME_CYCLES - 1 : 0);
  localparam logic [16:0]   TMO_LIM  = 17'(STALL_TIMEOUT);

  typedef enum logic [1:0] {RUN, STALL, RESUME} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [3:0]    res_cnt, res_nxt;
  logic [15:0]   tmo_cnt;
  logic [16:0]   tmo_inc;
  logic          ce_nxt, tmo_hit, any_req;

  assign any_req      = |stall_req;
  assign stall_active = (state != RUN);
  assign tmo_inc      = {1'b0, tmo_cnt} + 17'd1;
  assign tmo_hit      = (state == STALL) && (tmo_inc >= TMO_LIM);

  // Acks simply follow requests one cycle later; proc_ce is masked by the same requests.
  for (genvar i = 0; i < NUM_STALL; i++) begin : g_lane
    proc_clk_ack_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (stall_req[i]),
      .ack   (stall_ack[i])
    );
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    res_nxt   = res_cnt;
    ce_nxt    = 1'b0;
    case (state)
      RUN: begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
        ce_nxt  = (div_cnt == DIV_LAST) && !any_req;
        if (any_req) state_nxt = STALL;
      end
      STALL: begin
        if (!any_req) begin
          div_nxt = '0;
          res_nxt = '0;
          state_nxt = (RESUME_CYCLES == 0) ? RUN : RESUME;
        end
      end
      RESUME: begin
        if (any_req) begin
          state_nxt = STALL;
          res_nxt   = '0;
        end else if (res_cnt == RES_LAST) begin
          state_nxt = RUN;
          res_nxt   = '0;
          div_nxt   = '0;
        end else begin
          res_nxt = res_cnt + 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= RUN;
      div_cnt       <= '0;
      res_cnt       <= '0;
      tmo_cnt       <= '0;
      proc_ce       <= 1'b0;
      stall_timeout <= 1'b0;
    end else begin
      state   <= state_nxt;
      div_cnt <= div_nxt;
      res_cnt <= res_nxt;
      proc_ce <= ce_nxt;
      // Saturates so a very long stall cannot wrap back under the limit.
      if (state == STALL) begin
        if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
      end else begin
        tmo_cnt <= '0;
      end
      if (tmo_hit) stall_timeout <= 1'b1;
    end
  end

`ifdef PROC_CLK_PERF_EN
  // ce_count tracks pulses as they are issued, so it matches proc_ce on the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ce_count    <= '0;
      stall_count <= '0;
    end else begin
      ce_count <= ce_count + {31'd0, ce_nxt};
      if (state == STALL) stall_count <= stall_count + 32'd1;
    end
  end
`else
  assign ce_count    = 32'h0;
  assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_proc_clk_ctrl.sv
// Bench for proc_clk_ctrl: three configurations checked every cycle against a time-based reference model.
module tb_proc_clk_ctrl;
`ifdef PROC_CLK_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam int M_RUN = 0, M_STALL = 1, M_RES = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic [1:0]  rq_a = '0;
  logic [0:0]  rq_b = '0;
  logic [2:0]  rq_c = '0;
  logic        ce_a, act_a, to_a, ce_b, act_b, to_b, ce_c, act_c, to_c;
  logic [1:0]  ack_a;
  logic [0:0]  ack_b;
  logic [2:0]  ack_c;
  logic [31:0] cec_a, stc_a, cec_b, stc_b, cec_c, stc_c;

  proc_clk_ctrl #(.DIV(4), .NUM_STALL(2), .RESUME_CYCLES(2), .STALL_TIMEOUT(8)) u_a (
    .clk(clk), .rst_n(rst_n), .stall_req(rq_a), .proc_ce(ce_a), .stall_ack(ack_a),
    .stall_active(act_a), .stall_timeout(to_a), .ce_count(cec_a), .stall_count(stc_a));
  proc_clk_ctrl #(.DIV(1), .NUM_STALL(1), .RESUME_CYCLES(1), .STALL_TIMEOUT(1024)) u_b (
    .clk(clk), .rst_n(rst_n), .stall_req(rq_b), .proc_ce(ce_b), .stall_ack(ack_b),
    .stall_active(act_b), .stall_timeout(to_b), .ce_count(cec_b), .stall_count(stc_b));
  proc_clk_ctrl #(.DIV(2), .NUM_STALL(3), .RESUME_CYCLES(0), .STALL_TIMEOUT(5)) u_c (
    .clk(clk), .rst_n(rst_n), .stall_req(rq_c), .proc_ce(ce_c), .stall_ack(ack_c),
    .stall_active(act_c), .stall_timeout(to_c), .ce_count(cec_c), .stall_count(stc_c));

  int p_div [3] = '{4, 1, 2};
  int p_res [3] = '{2, 1, 0};
  int p_tmo [3] = '{8, 1024, 5};
  int p_ns  [3] = '{2, 1, 3};

  // Model state: phase, the edge at which the divider phase starts, resume end edge, stall length.
  int          mode [3], origin [3], rend [3], slen [3];
  int unsigned mcec [3], mstc [3];
  logic        e_ce [3], e_act [3], e_to [3];
  logic [7:0]  e_ack [3];
  int          t = 0;
  int unsigned checks = 0, errors = 0;

  typedef struct {
    logic rst_n; logic rb; logic ce_a; logic ce_b; logic ack_b; logic act_b;
  } vec_t;
  vec_t tbl [13];

  logic [2:0] cseq [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                            3'b001, 3'b011, 3'b010, 3'b010, 3'b000};
  logic [2:0] cack [10] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                            3'b001, 3'b011, 3'b010, 3'b010, 3'b000};

  function automatic logic [7:0] get_req(input int k);
    case (k)
      0:       return {6'd0, rq_a};
      1:       return {7'd0, rq_b};
      default: return {5'd0, rq_c};
    endcase
  endfunction

  task automatic set_req(input int k, input logic [7:0] v);
    case (k)
      0:       rq_a = v[1:0];
      1:       rq_b = v[0:0];
      default: rq_c = v[2:0];
    endcase
  endtask

  function automatic logic [31:0] obs(input int k, input int s);
    logic [31:0] v;
    v = '0;
    case (k)
      0: case (s) 0: v = 32'(ce_a); 1: v = 32'(ack_a); 2: v = 32'(act_a);
                  3: v = 32'(to_a); 4: v = cec_a; default: v = stc_a; endcase
      1: case (s) 0: v = 32'(ce_b); 1: v = 32'(ack_b); 2: v = 32'(act_b);
                  3: v = 32'(to_b); 4: v = cec_b; default: v = stc_b; endcase
      default: case (s) 0: v = 32'(ce_c); 1: v = 32'(ack_c); 2: v = 32'(act_c);
                  3: v = 32'(to_c); 4: v = cec_c; default: v = stc_c; endcase
    endcase
    return v;
  endfunction

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc %0d: got %0h want %0h", nm, k, t, got, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      logic anyr;
      anyr = |get_req(k);
      if (!rst_n) begin
        mode[k] = M_RUN; origin[k] = t + 1; slen[k] = 0;
        mcec[k] = 0; mstc[k] = 0;
        e_ce[k] = 1'b0; e_ack[k] = '0; e_act[k] = 1'b0; e_to[k] = 1'b0;
        continue;
      end
      e_ack[k] = get_req(k);
      e_ce[k]  = (mode[k] == M_RUN) && !anyr && (((t - origin[k]) % p_div[k]) == p_div[k] - 1);
      if (e_ce[k]) mcec[k]++;
      case (mode[k])
        M_RUN: if (anyr) begin mode[k] = M_STALL; slen[k] = 0; end
        M_STALL: begin
          mstc[k]++;
          slen[k]++;
          if (slen[k] >= p_tmo[k]) e_to[k] = 1'b1;
          if (!anyr) begin
            if (p_res[k] == 0) begin mode[k] = M_RUN; origin[k] = t + 1; end
            else begin mode[k] = M_RES; rend[k] = t + p_res[k]; end
          end
        end
        default: begin
          if (anyr) begin mode[k] = M_STALL; slen[k] = 0; end
          else if (t == rend[k]) begin mode[k] = M_RUN; origin[k] = t + 1; end
        end
      endcase
      e_act[k] = (mode[k] != M_RUN);
    end
    t++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk("proc_ce", k, obs(k, 0), 32'(e_ce[k]));
      chk("stall_ack", k, obs(k, 1), 32'(e_ack[k]));
      chk("stall_active", k, obs(k, 2), 32'(e_act[k]));
      chk("stall_timeout", k, obs(k, 3), 32'(e_to[k]));
      chk("ce_count", k, obs(k, 4), PERF ? mcec[k] : 32'd0);
      chk("stall_count", k, obs(k, 5), PERF ? mstc[k] : 32'd0);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    rq_a = '0; rq_b = '0; rq_c = '0;
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    logic       saw_ce;

    // Row 0 is the reset edge, rows 1..12 are edges 0..11 after release.
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      rst_n = tbl[i].rst_n;
      rq_b  = tbl[i].rb;
      cyc();
      chk("tbl_ce_a", 0, 32'(ce_a), 32'(tbl[i].ce_a));
      chk("tbl_ce_b", 1, 32'(ce_b), 32'(tbl[i].ce_b));
      chk("tbl_ack_b", 1, 32'(ack_b), 32'(tbl[i].ack_b));
      chk("tbl_act_b", 1, 32'(act_b), 32'(tbl[i].act_b));
    end
    chk("tbl_cec_a", 0, cec_a, PERF ? 32'd3 : 32'd0);
    chk("tbl_stc_b", 1, stc_b, PERF ? 32'd3 : 32'd0);

    // Overlapping channels on the DIV=2 instance.
    do_reset();
    for (int e = 0; e < 10; e++) begin
      rq_c = cseq[e];
      cyc();
      if (e >= 5) begin
        chk("ovl_ack_c", 2, 32'(ack_c), 32'(cack[e]));
        chk("ovl_ce_c", 2, 32'(ce_c), 32'd0);
      end
    end
    rq_c = '0;
    repeat (3) cyc();

    // Long stall on the STALL_TIMEOUT=8 instance.
    do_reset();
    repeat (2) cyc();
    for (int n = 1; n <= 20; n++) begin
      rq_a = 2'b01;
      cyc();
      chk("tmo_set", 0, 32'(to_a), (n >= 9) ? 32'd1 : 32'd0);
    end
    rq_a = '0;
    saw_ce = 1'b0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      chk("tmo_sticky", 0, 32'(to_a), 32'd1);
      if (ce_a) saw_ce = 1'b1;
    end
    chk("tmo_run_again", 0, 32'(saw_ce), 32'd1);

    // Reset in the middle of a stall on every instance.
    rq_a = 2'b11; rq_b = 1'b1; rq_c = 3'b101;
    repeat (3) cyc();
    do_reset();
    for (int k = 0; k < 3; k++)
      for (int s = 0; s < 6; s++) chk("midrst_zero", k, obs(k, s), 32'd0);
    for (int e = 0; e < 6; e++) begin
      cyc();
      chk("midrst_ce_a", 0, 32'(ce_a), (e == 3) ? 32'd1 : 32'd0);
      chk("midrst_ce_b", 1, 32'(ce_b), 32'd1);
    end

    // Random traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      for (int k = 0; k < 3; k++) begin
        v = get_req(k);
        for (int ch = 0; ch < p_ns[k]; ch++)
          if ($urandom_range(0, 7) == 0) v[ch] = ~v[ch];
        set_req(k, v);
      end
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
